// File: rtl/bus_request_arbiter.sv
// Round-robin arbiter and command sequencer sharing one cache-to-memory bus port.
// Optional watchdog enabled by defining ARB_WATCHDOG_EN.
module bus_request_arbiter #(
  parameter int unsigned CONNECTIONS = 2,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CONNECTIONS-1:0]                 req_valid,
  input  logic [CONNECTIONS-1:0]                 req_store,
  input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] req_addr,
  output logic [CONNECTIONS-1:0]                 req_ready,
  output logic [CONNECTIONS-1:0]                 grant,
  output logic [$clog2(CONNECTIONS)-1:0]         grant_id,
  output logic                                   bus_cmd_valid,
  output logic                                   bus_cmd_store,
  output logic [ADDR_WIDTH-1:0]                  bus_cmd_addr,
  input  logic                                   bus_cmd_ready,
  input  logic                                   bus_done,
  output logic                                   err_spurious_done,
  output logic                                   err_timeout
);

  localparam int unsigned IdW = $clog2(CONNECTIONS);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state;
  logic [IdW-1:0]   rr_ptr;
  logic [IdW-1:0]   owner;

  logic             any_req;
  logic             found;
  logic [IdW-1:0]   winner;
  logic [IdW-1:0]   sel;
  int unsigned      idx;
  logic [CONNECTIONS-1:0] win_oh;
  logic [IdW-1:0]   next_ptr;
  logic             finish;
  logic             wd_expire;

  // Unsupported configurations elaborate this marker block.
  if (CONNECTIONS < 2 || TIMEOUT == 0) begin : g_invalid_params
  end

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    any_req = |req_valid;
    found   = 1'b0;
    winner  = '0;
    sel     = '0;
    idx     = 0;
    for (int unsigned i = 0; i < CONNECTIONS; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= CONNECTIONS) idx = idx - CONNECTIONS;
      sel = IdW'(idx);
      if (!found && req_valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  assign next_ptr = (owner == IdW'(CONNECTIONS - 1)) ? '0 : owner + IdW'(1);

  assign finish = ((state == StIssue) && bus_cmd_ready && bus_done) ||
                  ((state == StWait) && (bus_done || wd_expire));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= StIdle;
      rr_ptr            <= '0;
      owner             <= '0;
      req_ready         <= '0;
      grant             <= '0;
      grant_id          <= '0;
      bus_cmd_valid     <= 1'b0;
      bus_cmd_store     <= 1'b0;
      bus_cmd_addr      <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        StIdle: begin
          if (bus_done) err_spurious_done <= 1'b1;
          if (any_req) begin
            owner         <= winner;
            grant_id      <= winner;
            grant         <= win_oh;
            req_ready     <= win_oh;
            bus_cmd_valid <= 1'b1;
            bus_cmd_store <= req_store[winner];
            bus_cmd_addr  <= req_addr[winner];
            state         <= StIssue;
          end
        end
        StIssue: begin
          if (bus_cmd_ready) begin
            bus_cmd_valid <= 1'b0;
            state         <= StWait;
          end else if (bus_done) begin
            err_spurious_done <= 1'b1;
          end
        end
        StWait: ;
        default: state <= StIdle;
      endcase
      // Completion (or watchdog expiry) releases the bus and rotates priority.
      if (finish) begin
        state    <= StIdle;
        grant    <= '0;
        grant_id <= '0;
        rr_ptr   <= next_ptr;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wd_cnt;

  assign wd_expire = (state == StWait) && !bus_done &&
                     ((wd_cnt + CntW'(1)) == CntW'(TIMEOUT));

  // Held at zero outside WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != StWait) wd_cnt <= '0;
      else                 wd_cnt <= wd_cnt + CntW'(1);
      if (wd_expire) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: directed scenarios plus randomized
// transactions against a transaction-level round-robin model.
module tb_bus_request_arbiter;

  localparam int C  = 3;
  localparam int AW = 32;
  localparam int TO = 16;
  localparam int IW = $clog2(C);

  logic              clk = 1'b0;
  logic              reset;
  logic [C-1:0]      req_valid, req_store, req_ready, grant;
  logic [C-1:0][AW-1:0] req_addr;
  logic [IW-1:0]     grant_id;
  logic              bus_cmd_valid, bus_cmd_store, bus_cmd_ready, bus_done;
  logic [AW-1:0]     bus_cmd_addr;
  logic              err_spurious_done, err_timeout;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  bus_request_arbiter #(.CONNECTIONS(C), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_addr(req_addr), .req_ready(req_ready), .grant(grant), .grant_id(grant_id),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_store(bus_cmd_store),
    .bus_cmd_addr(bus_cmd_addr), .bus_cmd_ready(bus_cmd_ready), .bus_done(bus_done),
    .err_spurious_done(err_spurious_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit expired");
    $fatal(1);
  end

  function automatic logic [C-1:0] oh(input int i);
    logic [C-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requesting index scanning up from ptr, modulo C.
  function automatic int model_winner(input int ptr, input logic [C-1:0] mask);
    for (int i = 0; i < C; i++) if (mask[(ptr + i) % C]) return (ptr + i) % C;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_store = '0; req_addr = '0;
    bus_cmd_ready = 1'b0; bus_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus_cmd_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_store = '0; req_addr = '0;
    bus_cmd_ready = 1'b0; bus_done = 1'b0;
    #1;
    checks++;
    if ({req_ready, grant, grant_id, bus_cmd_valid, bus_cmd_store, bus_cmd_addr,
         err_spurious_done, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b valid=%b addr=%h want all zero",
               grant, bus_cmd_valid, bus_cmd_addr);
    end
    do_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    req_valid = 3'b001; req_addr[0] = 32'h1000; req_store[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001 || grant !== 3'b001 || bus_cmd_valid !== 1'b1 ||
        bus_cmd_addr !== 32'h1000 || bus_cmd_store !== 1'b0) begin
      errors++;
      $display("FAIL single_issue got rdy=%b gnt=%b v=%b a=%h s=%b want 001 001 1 1000 0",
               req_ready, grant, bus_cmd_valid, bus_cmd_addr, bus_cmd_store);
    end
    req_valid = '0; bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0;
    checks++;
    if (bus_cmd_valid !== 1'b0 || grant !== 3'b001 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL single_wait got v=%b gnt=%b rdy=%b want 0 001 000",
               bus_cmd_valid, grant, req_ready);
    end
    @(negedge clk);
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL single_release got gnt=%b want 000", grant);
    end
  endtask

  task automatic test_contention();
    int exp_seq[4] = '{0, 1, 0, 1};
    bit ok;
    do_reset();
    req_valid = 3'b011; req_store = 3'b010;
    req_addr[0] = 32'hA000; req_addr[1] = 32'hB000;
    for (int k = 0; k < 4; k++) begin
      wait_issue(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL contention_issue_timeout txn=%0d got no cmd want cmd", k);
      end
      checks++;
      if (grant_id !== IW'(exp_seq[k]) || bus_cmd_store !== (exp_seq[k] == 1)) begin
        errors++;
        $display("FAIL contention_order txn=%0d got id=%0d st=%b want id=%0d",
                 k, grant_id, bus_cmd_store, exp_seq[k]);
      end
      bus_cmd_ready = 1'b1;
      @(negedge clk);
      bus_cmd_ready = 1'b0;
      @(negedge clk);
      bus_done = 1'b1;
      @(negedge clk);
      bus_done = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int pulses;
    do_reset();
    req_valid = 3'b001; req_addr[0] = 32'hCAFE0040; req_store[0] = 1'b1;
    @(negedge clk);
    pulses = (req_ready != '0) ? 1 : 0;
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      req_addr[0] = $urandom; req_store[0] = 1'b0;
      @(negedge clk);
      if (req_ready != '0) pulses++;
      checks++;
      if (bus_cmd_valid !== 1'b1 || bus_cmd_addr !== 32'hCAFE0040 ||
          bus_cmd_store !== 1'b1 || grant !== 3'b001) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b a=%h s=%b g=%b want 1 cafe0040 1 001",
                 i, bus_cmd_valid, bus_cmd_addr, bus_cmd_store, grant);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL backpressure_ready_pulses got %0d want 1", pulses);
    end
    bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL b2b_first got gnt=%b want 001", grant);
    end
    bus_cmd_ready = 1'b1; bus_done = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0; bus_done = 1'b0;
    checks++;
    if (grant !== 3'b000 || bus_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got gnt=%b v=%b want 000 0", grant, bus_cmd_valid);
    end
    @(negedge clk);
    checks++;
    if (grant !== 3'b010 || grant_id !== IW'(1) || bus_cmd_valid !== 1'b1 ||
        err_spurious_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got gnt=%b id=%0d v=%b sp=%b want 010 1 1 0",
               grant, grant_id, bus_cmd_valid, err_spurious_done);
    end
    req_valid = '0; bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_spurious_done !== 1'b1 || grant !== 3'b000) begin
      errors++;
      $display("FAIL spurious_idle got sp=%b gnt=%b want 1 000", err_spurious_done, grant);
    end
    // Complete a transaction for requester 0 so priority moves to 1.
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = '0; bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0; req_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (grant_id !== IW'(1)) begin
      errors++;
      $display("FAIL spurious_rotate got id=%0d want 1", grant_id);
    end
    bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || bus_cmd_valid !== 1'b0 || req_ready !== '0 || grant_id !== '0 ||
        err_spurious_done !== 1'b0 || bus_cmd_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait got gnt=%b v=%b sp=%b want 000 0 0",
               grant, bus_cmd_valid, err_spurious_done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_id !== IW'(0) || grant !== 3'b001) begin
      errors++;
      $display("FAIL reset_rr_ptr got id=%0d gnt=%b want 0 001", grant_id, grant);
    end
    // Done without ready while issuing is spurious and leaves the command in place.
    req_valid = '0; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    checks++;
    if (bus_cmd_valid !== 1'b1 || grant !== 3'b001 || err_spurious_done !== 1'b1) begin
      errors++;
      $display("FAIL spurious_issue got v=%b gnt=%b sp=%b want 1 001 1",
               bus_cmd_valid, grant, err_spurious_done);
    end
    bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = '0; bus_cmd_ready = 1'b1;
    @(negedge clk);
    bus_cmd_ready = 1'b0;
`ifdef ARB_WATCHDOG_EN
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (grant !== 3'b001 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_early got gnt=%b to=%b want 001 0", grant, err_timeout);
    end
    @(negedge clk);
    checks++;
    if (grant !== 3'b000 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_fire got gnt=%b to=%b want 000 1", grant, err_timeout);
    end
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0; req_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (err_spurious_done !== 1'b1 || grant_id !== IW'(1)) begin
      errors++;
      $display("FAIL watchdog_after got sp=%b id=%0d want 1 1", err_spurious_done, grant_id);
    end
    req_valid = '0;
`else
    repeat (3 * TO) @(negedge clk);
    checks++;
    if (grant !== 3'b001 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog_hold got gnt=%b to=%b want 001 0", grant, err_timeout);
    end
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    checks++;
    if (grant !== 3'b000 || err_spurious_done !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog_done got gnt=%b sp=%b want 000 0", grant, err_spurious_done);
    end
`endif
  endtask

  task automatic test_random();
    logic [C-1:0] mask;
    logic [AW-1:0] exp_addr;
    logic exp_store;
    int w, bp, dly;
    bit shortcut;
    do_reset();
    for (int t = 0; t < 150; t++) begin
      mask = C'($urandom_range(1, (1 << C) - 1));
      for (int i = 0; i < C; i++) begin
        req_addr[i] = $urandom; req_store[i] = 1'($urandom_range(0, 1));
      end
      req_valid = mask;
      w = model_winner(m_ptr, mask);
      exp_addr = req_addr[w]; exp_store = req_store[w];
      @(negedge clk);
      checks++;
      if (grant !== oh(w) || grant_id !== IW'(w) || req_ready !== oh(w) ||
          bus_cmd_valid !== 1'b1 || bus_cmd_addr !== exp_addr ||
          bus_cmd_store !== exp_store) begin
        errors++;
        $display("FAIL rand_issue txn=%0d got gnt=%b id=%0d rdy=%b a=%h s=%b want id=%0d a=%h s=%b",
                 t, grant, grant_id, req_ready, bus_cmd_addr, bus_cmd_store, w, exp_addr,
                 exp_store);
      end
      req_valid[w] = 1'b0;
      req_addr[w] = $urandom; req_store[w] = ~exp_store;
      bp = $urandom_range(0, 3);
      shortcut = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || bus_cmd_valid !== 1'b1 || bus_cmd_addr !== exp_addr ||
            grant !== oh(w)) begin
          errors++;
          $display("FAIL rand_hold txn=%0d got rdy=%b v=%b a=%h want 000 1 %h",
                   t, req_ready, bus_cmd_valid, bus_cmd_addr, exp_addr);
        end
      end
      bus_cmd_ready = 1'b1; bus_done = shortcut;
      @(negedge clk);
      bus_cmd_ready = 1'b0; bus_done = 1'b0;
      if (!shortcut) begin
        dly = $urandom_range(0, 3);
        repeat (dly) @(negedge clk);
        checks++;
        if (grant !== oh(w) || bus_cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_wait txn=%0d got gnt=%b v=%b want %b 0",
                   t, grant, bus_cmd_valid, oh(w));
        end
        bus_done = 1'b1;
        @(negedge clk);
        bus_done = 1'b0;
      end
      checks++;
      if (grant !== '0 || err_spurious_done !== 1'b0) begin
        errors++;
        $display("FAIL rand_release txn=%0d got gnt=%b sp=%b want 000 0",
                 t, grant, err_spurious_done);
      end
      m_ptr = (w + 1) % C;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_spurious_and_reset();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
